// File: rtl/brick_map_if.sv
// Hit and cell-query bus between game control / collision logic and brick_map.
// Hits are single-cycle pulses with no ready: every hit_valid cycle is consumed (applied or dropped).
interface brick_map_if;
  logic       hit_valid;
  logic [4:0] hit_col;
  logic [3:0] hit_row;
  logic       hit_fire;
  logic [4:0] q_col;
  logic [3:0] q_row;
  logic [3:0] q_type;

  modport master (
    output hit_valid, hit_col, hit_row, hit_fire, q_col, q_row,
    input  q_type
  );

  modport slave (
    input  hit_valid, hit_col, hit_row, hit_fire, q_col, q_row,
    output q_type
  );
endinterface

// File: rtl/brick_map.sv
// Brick-field store: stage init sweep, ball-hit updates, per-pixel and query lookups.
// Optional gadget-drop pulse enabled by defining BRICK_MAP_GADGET_DROP_EN.
module brick_map #(
  parameter int COLS  = 20,
  parameter int ROWS  = 16,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [2:0]       i_stage_numb,
  input  logic             i_stage_load,
  brick_map_if.slave       bus,
  output logic [3:0]       is_brick,
  output logic [CNT_W-1:0] bricks_left,
  output logic             init_busy,
  output logic             stage_clear,
  output logic             gadget_drop,
  output logic [4:0]       gadget_col,
  output logic [3:0]       gadget_row
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  state_t state, state_nxt;

  logic [3:0]    cells [CELLS];
  logic [4:0]    init_col;
  logic [3:0]    init_row;
  logic          init_last, init_we;
  logic [AW-1:0] init_addr;
  logic [3:0]    init_data;
  logic          hit_ok, hit_dec;
  logic [AW-1:0] hit_addr;
  logic [3:0]    hit_old, hit_new;
  logic          pix_ok, q_ok;
  logic [AW-1:0] pix_addr, q_addr;

  function automatic logic [3:0] cell_pattern(input int c, input int r, input int s);
    if (c == 0 || c == COLS - 1 || r < 2 || r > 9) return 4'd0;
    if (r <= 3) return 4'd1;
    if (r <= 7) return 4'd2;
    if (r == 8) return ((c + s) % 2 == 0) ? 4'd3 : 4'd2;
    return (c % 4 == 0 && s >= 2) ? 4'd4 : 4'd0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_stage_load) state_nxt = INIT;
      INIT:    if (!i_stage_load && init_last) state_nxt = RUN;
      RUN:     if (i_stage_load) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    init_busy   = (state == INIT);
    init_we     = (state == INIT) && !i_stage_load;
    stage_clear = (state == RUN) && (bricks_left == '0);
  end

  assign init_last = (init_col == 5'(COLS - 1)) && (init_row == 4'(ROWS - 1));
  assign init_addr = AW'(int'(init_row) * COLS + int'(init_col));
  assign init_data = cell_pattern(int'(init_col), int'(init_row), int'(i_stage_numb));

  // A load in the same cycle always wins over a hit.
  assign hit_ok   = bus.hit_valid && (state == RUN) && !i_stage_load &&
                    (int'(bus.hit_col) < COLS) && (int'(bus.hit_row) < ROWS);
  assign hit_addr = AW'(int'(bus.hit_row) * COLS + int'(bus.hit_col));
  assign hit_old  = hit_ok ? cells[hit_addr] : 4'd0;

  always_comb begin
    case (hit_old)
      4'd1:       hit_new = bus.hit_fire ? 4'd0 : 4'd2;
      4'd2, 4'd3: hit_new = 4'd0;
      default:    hit_new = hit_old;
    endcase
  end

  assign hit_dec = hit_ok && (hit_old inside {4'd1, 4'd2, 4'd3}) && (hit_new == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= 4'd0;
    end else if (init_we) begin
      cells[init_addr] <= init_data;
    end else if (hit_ok) begin
      cells[hit_addr] <= hit_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_col    <= '0;
      init_row    <= '0;
      bricks_left <= '0;
    end else if (i_stage_load) begin
      init_col    <= '0;
      init_row    <= '0;
      bricks_left <= '0;
    end else if (init_we) begin
      if (init_data inside {4'd1, 4'd2, 4'd3}) bricks_left <= bricks_left + 1'b1;
      if (init_col == 5'(COLS - 1)) begin
        init_col <= '0;
        init_row <= init_last ? 4'd0 : init_row + 4'd1;
      end else begin
        init_col <= init_col + 5'd1;
      end
    end else if (hit_dec && bricks_left != '0) begin
      bricks_left <= bricks_left - 1'b1;
    end
  end

  assign pix_ok   = (DrawX < 10'(COLS * 32)) && (DrawY < 10'(ROWS * 16));
  assign pix_addr = AW'(int'(DrawY[8:4]) * COLS + int'(DrawX[9:5]));
  assign q_ok     = (int'(bus.q_col) < COLS) && (int'(bus.q_row) < ROWS);
  assign q_addr   = AW'(int'(bus.q_row) * COLS + int'(bus.q_col));

  // Reads see the array before this cycle's hit write, so a same-cell query returns the pre-hit type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_brick   <= 4'd0;
      bus.q_type <= 4'd0;
    end else begin
      is_brick   <= ((state == RUN) && pix_ok) ? cells[pix_addr] : 4'd0;
      bus.q_type <= ((state == RUN) && q_ok)   ? cells[q_addr]   : 4'd0;
    end
  end

`ifdef BRICK_MAP_GADGET_DROP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gadget_drop <= 1'b0;
      gadget_col  <= 5'd0;
      gadget_row  <= 4'd0;
    end else begin
      gadget_drop <= hit_ok && (hit_old == 4'd3);
      if (hit_ok && hit_old == 4'd3) begin
        gadget_col <= bus.hit_col;
        gadget_row <= bus.hit_row;
      end
    end
  end
`else
  assign gadget_drop = 1'b0;
  assign gadget_col  = 5'd0;
  assign gadget_row  = 4'd0;
`endif
endmodule

// File: tb/tb_brick_map.sv
// Self-checking bench for brick_map against a cell-array reference model.
module tb_brick_map;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [2:0] i_stage_numb = '0;
  logic       i_stage_load = 1'b0;
  logic [3:0] is_brick;
  logic [8:0] bricks_left;
  logic       init_busy, stage_clear, gadget_drop;
  logic [4:0] gadget_col;
  logic [3:0] gadget_row;

  brick_map_if bus();

  brick_map dut (
    .clk(clk), .rst(rst), .DrawX(DrawX), .DrawY(DrawY),
    .i_stage_numb(i_stage_numb), .i_stage_load(i_stage_load), .bus(bus),
    .is_brick(is_brick), .bricks_left(bricks_left), .init_busy(init_busy),
    .stage_clear(stage_clear), .gadget_drop(gadget_drop),
    .gadget_col(gadget_col), .gadget_row(gadget_row)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: field as a 2-D array of brick types
  int m_cell [16][20];
  int m_cnt  = 0;
  bit m_run  = 0;
  int m_gcol = 0, m_grow = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int pat(input int c, input int r, input int s);
    if (c == 0 || c == 19 || r < 2 || r > 9) return 0;
    if (r == 2 || r == 3) return 1;
    if (r >= 4 && r <= 7) return 2;
    if (r == 8) return ((c + s) % 2 == 0) ? 3 : 2;
    return (c % 4 == 0 && s >= 2) ? 4 : 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 20; c++) m_cell[r][c] = 0;
    m_cnt = 0; m_run = 0; m_gcol = 0; m_grow = 0;
  endtask

  task automatic model_load(input int s);
    m_cnt = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 20; c++) begin
        m_cell[r][c] = pat(c, r, s);
        if (m_cell[r][c] >= 1 && m_cell[r][c] <= 3) m_cnt++;
      end
    m_run = 1;
  endtask

  task automatic idle_tick();
    bus.hit_valid = 1'b0; i_stage_load = 1'b0;
    @(posedge clk); #1;
  endtask

  // One clock with optional hit / load, a query and a pixel; checks all registered outputs.
  task automatic step(input bit hv, input int hc, input int hr, input bit hf,
                      input int qc, input int qr, input int dx, input int dy,
                      input bit ld, input int stg);
    int exp_q, exp_px, old_t, new_t;
    bit exp_gd;
    bus.hit_valid = hv; bus.hit_col = 5'(hc); bus.hit_row = 4'(hr); bus.hit_fire = hf;
    bus.q_col = 5'(qc); bus.q_row = 4'(qr);
    DrawX = 10'(dx); DrawY = 10'(dy);
    i_stage_load = ld; i_stage_numb = 3'(stg);
    exp_q  = (m_run && qc < 20 && qr < 16) ? m_cell[qr][qc] : 0;
    exp_px = (m_run && dx < 640 && dy < 256) ? m_cell[dy / 16][dx / 32] : 0;
    exp_gd = 0;
    if (ld) begin
      m_run = 0; m_cnt = 0;
    end else if (hv && m_run && hc < 20 && hr < 16) begin
      old_t = m_cell[hr][hc];
      if (old_t == 1)      new_t = hf ? 0 : 2;
      else if (old_t == 2) new_t = 0;
      else if (old_t == 3) new_t = 0;
      else                 new_t = old_t;
      m_cell[hr][hc] = new_t;
      if (old_t >= 1 && old_t <= 3 && new_t == 0 && m_cnt > 0) m_cnt--;
`ifdef BRICK_MAP_GADGET_DROP_EN
      if (old_t == 3) begin exp_gd = 1; m_gcol = hc; m_grow = hr; end
`endif
    end
    @(posedge clk); #1;
    bus.hit_valid = 1'b0; i_stage_load = 1'b0;
    check("q_type", int'(bus.q_type), exp_q);
    check("is_brick", int'(is_brick), exp_px);
    check("bricks_left", int'(bricks_left), m_cnt);
    check("stage_clear", int'(stage_clear), (m_run && m_cnt == 0) ? 1 : 0);
    check("gadget_drop", int'(gadget_drop), int'(exp_gd));
    check("gadget_col", int'(gadget_col), m_gcol);
    check("gadget_row", int'(gadget_row), m_grow);
  endtask

  task automatic wait_init(input int s);
    int n = 0;
    while (init_busy && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("init_len", n, 320);
    model_load(s);
    check("init_count", int'(bricks_left), 126);
    check("init_model_count", m_cnt, 126);
    check("init_clear", int'(stage_clear), 0);
  endtask

  task automatic load_stage(input int s);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, s);
    check("load_busy", int'(init_busy), 1);
    wait_init(s);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hit_valid = 0; bus.hit_col = 0; bus.hit_row = 0; bus.hit_fire = 0;
    bus.q_col = 0; bus.q_row = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(init_busy), 0);
    check("rst_count", int'(bricks_left), 0);
    check("rst_clear", int'(stage_clear), 0);
    check("rst_q", int'(bus.q_type), 0);
    check("rst_px", int'(is_brick), 0);
    rst = 1'b0;
    idle_tick();

    // Stage 0 and its boundary queries
    load_stage(0);
    step(0, 0, 0, 0, 1, 8, 0, 0, 0, 0);
    check("q_1_8_s0", int'(bus.q_type), 2);
    step(0, 0, 0, 0, 2, 8, 0, 0, 0, 0);
    check("q_2_8_s0", int'(bus.q_type), 3);
    step(0, 0, 0, 0, 4, 9, 0, 0, 0, 0);
    check("q_4_9_s0", int'(bus.q_type), 0);

    // Stage 2: pixel lookups
    load_stage(2);
    step(0, 0, 0, 0, 0, 0, 128, 144, 0, 0);
    check("px_128_144", int'(is_brick), 4);
    step(0, 0, 0, 0, 0, 0, 128, 300, 0, 0);
    check("px_y300", int'(is_brick), 0);
    step(0, 0, 0, 0, 0, 0, 0, 144, 0, 0);
    check("px_x0", int'(is_brick), 0);
    step(0, 0, 0, 0, 0, 0, 700, 40, 0, 0);

    // Normal hits on a hard brick, an unbreakable brick, then fire hits
    step(1, 3, 2, 0, 3, 2, 0, 0, 0, 0);
    check("hard_pre", int'(bus.q_type), 1);
    check("hard_cnt1", int'(bricks_left), 126);
    step(1, 3, 2, 0, 3, 2, 0, 0, 0, 0);
    check("hard_mid", int'(bus.q_type), 2);
    check("hard_cnt2", int'(bricks_left), 125);
    step(0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
    check("hard_post", int'(bus.q_type), 0);
    step(1, 4, 9, 0, 4, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 4, 9, 0, 0, 0, 0);
    check("unbreak", int'(bus.q_type), 4);
    step(1, 5, 3, 1, 5, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 3, 0, 0, 0, 0);
    check("fire_hard", int'(bus.q_type), 0);
    check("fire_cnt", int'(bricks_left), 124);
    step(1, 2, 8, 1, 2, 8, 0, 0, 0, 0);
    step(1, 25, 3, 0, 25, 3, 0, 0, 0, 0);

    // Hit coincident with load, then restart mid-sweep
    step(1, 6, 4, 1, 6, 4, 0, 0, 1, 1);
    check("hitload_busy", int'(init_busy), 1);
    repeat (100) idle_tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    wait_init(1);
    step(0, 0, 0, 0, 6, 4, 0, 0, 0, 0);
    check("hitload_cell", int'(bus.q_type), 2);

    // Reset in the middle of the sweep
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    repeat (50) idle_tick();
    rst = 1'b1; #1;
    check("rst_mid_busy", int'(init_busy), 0);
    check("rst_mid_count", int'(bricks_left), 0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 0, 0, 0, 3, 3, 100, 40, 0, 0);

    // Randomised hits, queries and pixels
    begin
      int s;
      s = $urandom_range(0, 7);
      load_stage(s);
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 1), $urandom_range(0, 21), $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 21), $urandom_range(0, 15),
             $urandom_range(0, 700), $urandom_range(0, 300), 0, 0);
    end

    // Clear the whole field with fire hits
    load_stage(4);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 20; c++)
        if (m_cell[r][c] >= 1 && m_cell[r][c] <= 3)
          step(1, c, r, 1, c, r, c * 32, r * 16, 0, 0);
    check("clear_count", int'(bricks_left), 0);
    check("clear_flag", int'(stage_clear), 1);
    step(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    check("clear_sat", int'(bricks_left), 0);
    check("clear_hold", int'(stage_clear), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
